// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider with 50% duty output for even and
// odd ratios. Ratio changes, enable and stop all take effect only at period
// boundaries, so clk_out never produces a runt pulse.
module freq_divider_prog #(
  parameter int W       = 8,
  parameter int DIV_RST = 3
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         clk_out,
  output logic         tick,
  output logic         load_ack,
  output logic [W-1:0] count,
  output logic [W-1:0] div_active
);

  localparam logic [W-1:0] ONE       = W'(1);
  localparam logic [W-1:0] TWO       = W'(2);
  localparam logic [W:0]   ONE_X     = (W+1)'(1);
  localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
  localparam logic [W-1:0] CNT_RST_W = W'(DIV_RST - 1);

  // Divisors below 2 cannot produce a clock; force them up to 2.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] x);
    return (x < TWO) ? TWO : x;
  endfunction

  logic [W-1:0] pend_div, pend_div_nxt;
  logic         pend_vld, pend_vld_nxt;
  logic [W-1:0] div_nxt, count_nxt, req_div;
  logic         tick_nxt, ack_nxt, req_vld, boundary;
  logic [W:0]   half_nxt;
  logic         p_nxt, p_q, n_q;

  // Next-state: count within the period, or apply pending divisor / enable at the boundary.
  always_comb begin
    boundary     = (count == div_active - ONE);
    // A load arriving on the boundary edge itself is applied at that boundary.
    req_vld      = pend_vld | div_load;
    req_div      = div_load ? div_in : pend_div;
    div_nxt      = div_active;
    count_nxt    = count + ONE;
    tick_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    pend_div_nxt = pend_div;
    pend_vld_nxt = pend_vld;
    if (div_load) begin
      pend_div_nxt = div_in;
      pend_vld_nxt = 1'b1;
    end
    if (boundary) begin
      if (req_vld) begin
        div_nxt = clamp_div(req_div);
      end
      ack_nxt      = req_vld;
      pend_vld_nxt = 1'b0;
      if (en) begin
        count_nxt = '0;
        tick_nxt  = 1'b1;
      end else begin
        // Parking at N-1 keeps every following posedge a boundary while idle.
        count_nxt = div_nxt - ONE;
      end
    end
    // High phase covers the first ceil(N/2) counts of the period.
    half_nxt = ({1'b0, div_nxt} + ONE_X) >> 1;
    p_nxt    = ({1'b0, count_nxt} < half_nxt);
  end

  // Posedge state: counter, active divisor, pending divisor, pulses and phase flop.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count      <= CNT_RST_W;
      div_active <= DIV_RST_W;
      pend_div   <= '0;
      pend_vld   <= 1'b0;
      tick       <= 1'b0;
      load_ack   <= 1'b0;
      p_q        <= 1'b0;
    end else begin
      count      <= count_nxt;
      div_active <= div_nxt;
      pend_div   <= pend_div_nxt;
      pend_vld   <= pend_vld_nxt;
      tick       <= tick_nxt;
      load_ack   <= ack_nxt;
      p_q        <= p_nxt;
    end
  end

  // Negedge copy of the phase flop; ANDing with it delays the rise by half a cycle for odd N.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  assign clk_out = div_active[0] ? (p_q & n_q) : p_q;

endmodule

// File: tb/tb_freq_divider_prog.sv
// Bench for freq_divider_prog: a vector table from reset, hand-written
// sequences for the multi-cycle corners, then random traffic against a
// period-level reference model.
module tb_freq_divider_prog;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         clk_out;
  logic         tick;
  logic         load_ack;
  logic [W-1:0] count;
  logic [W-1:0] div_active;

  freq_divider_prog #(.W(W), .DIV_RST(3)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .clk_out   (clk_out),
    .tick      (tick),
    .load_ack  (load_ack),
    .count     (count),
    .div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: position in the current period and its length.
  int m_cnt, m_n, m_pd;
  bit m_pv, m_tick, m_ack;
  bit s_neg, s_pos;

  typedef struct {
    bit       en;
    bit       ld;
    bit [7:0] din;
    int       cnt;
    int       div;
    bit       tck;
    bit       ack;
    bit       clk;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  // clk_out is high on doubled time T within [odd, N+odd) of the period.
  function automatic bit clk_exp(input int c, input int n, input bit half);
    int t;
    int o;
    t = 2 * c + int'(half);
    o = n % 2;
    return (t >= o) && (t < n + o);
  endfunction

  task automatic model_reset();
    m_n = 3; m_cnt = 2; m_pv = 0; m_pd = 0; m_tick = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int d);
    int nn;
    if (m_cnt == m_n - 1) begin
      nn    = l ? clampi(d) : (m_pv ? clampi(m_pd) : m_n);
      m_ack = l || m_pv;
      m_n   = nn;
      m_cnt = e ? 0 : nn - 1;
      m_tick = e;
      m_pv  = 0;
    end else begin
      m_cnt++;
      m_tick = 0;
      m_ack  = 0;
      if (l) begin
        m_pv = 1;
        m_pd = d;
      end
    end
  endtask

  // One clk_in cycle: drive inputs, check at negedge+1 and posedge+1.
  task automatic step(input bit e, input bit l, input int d);
    en = e; div_load = l; div_in = W'(d);
    @(negedge clk_in);
    #1;
    s_neg = clk_out;
    chk("clk_neg", clk_out, clk_exp(m_cnt, m_n, 1'b1));
    @(posedge clk_in);
    model_step(e, l, d);
    #1;
    s_pos = clk_out;
    chk("count", count, m_cnt);
    chk("div_active", div_active, m_n);
    chk("tick", tick, m_tick);
    chk("load_ack", load_ack, m_ack);
    chk("clk_pos", clk_out, clk_exp(m_cnt, m_n, 1'b0));
  endtask

  task automatic run_to(input int c);
    int k;
    for (k = 0; k < 600; k++) begin
      if (m_cnt == c) break;
      step(1, 0, 0);
    end
    if (k == 600) chk("run_to_timeout", 0, 1);
  endtask

  task automatic settle(input int n);
    int k;
    step(1, 1, n);
    for (k = 0; k < 600; k++) begin
      if (m_tick && m_n == n) break;
      step(1, 0, 0);
    end
    if (k == 600) chk("settle_timeout", 0, 1);
  endtask

  // From a tick, count high half-cycles over one period; 50% duty means N of 2N.
  task automatic measure_period(input int n);
    int k;
    int sum;
    for (k = 0; k < 600; k++) begin
      if (m_tick) break;
      step(1, 0, 0);
    end
    if (k == 600) chk("measure_sync_timeout", 0, 1);
    sum = int'(s_pos);
    for (int j = 1; j <= n; j++) begin
      step(1, 0, 0);
      sum += int'(s_neg);
      if (j < n) sum += int'(s_pos);
      if (j < n) chk("no_early_tick", tick, 0);
    end
    chk("period_tick", tick, 1);
    chk("duty_half_cycles", sum, n);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
    model_reset();
    tbl[0]  = '{1, 1, 4, 0, 4, 1, 1, 1};
    tbl[1]  = '{1, 0, 0, 1, 4, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 2, 4, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 3, 4, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 4, 1, 0, 1};
    tbl[5]  = '{1, 1, 0, 1, 4, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 2, 4, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 3, 4, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 2, 1, 1, 1};
    tbl[9]  = '{1, 1, 1, 1, 2, 0, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 2, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 1, 2, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 2, 0, 0, 0};
    tbl[13] = '{0, 1, 5, 4, 5, 0, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 5, 1, 0, 0};
    tbl[15] = '{1, 0, 0, 1, 5, 0, 0, 1};
    tbl[16] = '{1, 0, 0, 2, 5, 0, 0, 1};
    tbl[17] = '{1, 0, 0, 3, 5, 0, 0, 0};

    // Reset values
    @(posedge clk_in);
    #1;
    chk("rst_count", count, 2);
    chk("rst_div", div_active, 3);
    chk("rst_tick", tick, 0);
    chk("rst_ack", load_ack, 0);
    chk("rst_clk", clk_out, 0);
    #1 rst = 1'b0;

    // Table-driven vectors from reset
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].en, tbl[i].ld, int'(tbl[i].din));
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_div", i), div_active, tbl[i].div);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tck);
      chk($sformatf("tbl%0d_ack", i), load_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].clk);
    end

    // Duty and period for even and odd ratios
    settle(4);   measure_period(4);
    settle(5);   measure_period(5);
    settle(3);   measure_period(3);
    settle(255); measure_period(255);
    chk("wrap_count_max", count, 0);

    // Mid-period change: 6-cycle period completes, then 3
    settle(6);
    run_to(2);
    step(1, 1, 3);
    run_to(5);
    step(1, 0, 0);
    chk("mid_div3", div_active, 3);
    chk("mid_ack_with_tick", int'(load_ack & tick), 1);
    measure_period(3);

    // Second load overwrites the pending value
    settle(6);
    run_to(2);
    step(1, 1, 3);
    run_to(4);
    step(1, 1, 7);
    step(1, 0, 0);
    chk("overwrite_div7", div_active, 7);
    chk("overwrite_ack", load_ack, 1);
    chk("overwrite_tick", tick, 1);

    // Enable drop at count 1 of N=8, idle load, restart
    settle(8);
    run_to(1);
    for (int k = 0; k < 8; k++) step(0, 0, 0);
    chk("idle_count7", count, 7);
    chk("idle_clk_low", clk_out, 0);
    step(0, 1, 4);
    chk("idle_load_div", div_active, 4);
    chk("idle_load_count", count, 3);
    step(0, 0, 0);
    chk("idle_hold_count", count, 3);
    step(1, 0, 0);
    chk("restart_tick", tick, 1);
    chk("restart_count", count, 0);
    measure_period(4);

    // Asynchronous reset in a high phase discards a pending load
    settle(4);
    step(1, 1, 9);
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_low", clk_out, 0);
    chk("arst_count", count, 2);
    chk("arst_div", div_active, 3);
    chk("arst_tick", tick, 0);
    chk("arst_ack", load_ack, 0);
    @(posedge clk_in);
    #2 rst = 1'b0;
    model_reset();
    step(1, 0, 0);
    chk("arst_first_tick", tick, 1);
    chk("arst_pending_dropped", div_active, 3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit e;
      bit l;
      int d;
      e = ($urandom % 8) != 0;
      l = ($urandom % 12) == 0;
      case ($urandom % 6)
        0:       d = $urandom % 3;
        1:       d = 255;
        default: d = 2 + ($urandom % 30);
      endcase
      step(e, l, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_divider_prog.md
# freq_divider_prog

Runtime-programmable integer clock divider: divides `clk_in` by any N from 2 to 2^W−1 and produces a 50 % duty-cycle `clk_out` for both even and odd N. It replaces the fixed divide-by-3 block in the clock-generation area. It adds a glitch-free ratio change at period boundaries, a clean enable and stop, and a period tick for downstream logic.

## Interface
- `W`, default 8: width of the divisor and counter. The maximum N is 2^W−1.
- `DIV_RST`, default 3: divisor in effect after reset. It must be between 2 and 2^W−1.

Ports:
- `clk_in`  input  1  the single clock. Rising and falling edges are both used.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  run enable. Sampled only at period boundaries.
- `div_in`  input  W  requested divisor.
- `div_load`  input  1  one-cycle strobe, sampled at posedge, that captures `div_in`.
- `clk_out`  output  1  divided clock.
- `tick`  output  1  registered pulse, high for the cycle in which `count==0`.
- `load_ack`  output  1  one-cycle pulse when a pending divisor takes effect.
- `count`  output  W  posedge phase counter, range 0..N−1.
- `div_active`  output  W  divisor currently in effect.

## Operation
- **Clamping.** clamp(x) = 2 if x<2, else x. It is applied to every divisor before use. Let N = `div_active` and H = ceil(N/2).
- **Boundary.** A boundary is any posedge at which `count==N−1`.
- **Counting.** At a non-boundary posedge, `count` increments by 1.
- **Boundary update.** At a boundary posedge, in order:
  - If a divisor is pending, N' = clamp(pending); otherwise N' = N.
  - `div_active` <= N'.
  - If `en`=1, `count` <= 0 and `tick` <= 1. If `en`=0, `count` <= N'−1; this is the idle state and `tick` stays 0.
  - `load_ack` <= 1 if a divisor was applied, else 0.
  - The pending flag clears.
- **Pending divisor.** `div_load`=1 at a posedge writes `div_in` into the pending register and sets the pending flag. The last write wins.
  - If `div_load` coincides with a boundary posedge, that `div_in` is the divisor applied at that boundary.
- **Phase flops.**
  - `p_q` (posedge) <= (count_next < H'), where count_next and H' are the values after the edge.
  - `n_q` (negedge) <= `p_q`.
- **Output.**
  - N even: `clk_out` = `p_q`, giving H cycles high and H cycles low.
  - N odd: `clk_out` = `p_q & n_q`, giving N/2 cycles high, rising a half-cycle after the period posedge.
  - `clk_out` is derived only from flops, with no other combinational terms.
- **Enable.**
  - Dropping `en` mid-period never truncates the period. The divider stops at the next boundary with `clk_out` low.
  - While idle, every posedge is a boundary, so a pending load applies on the next posedge.
  - Raising `en` while idle starts a full period on the next posedge.

## Timing
- **Reset values.** `count`=DIV_RST−1, `div_active`=DIV_RST, `p_q`=`n_q`=0, `clk_out`=0, `tick`=0, `load_ack`=0, pending flag cleared.
  - Reset asserted at any time forces `clk_out` low immediately (asynchronously) and discards any pending load.
- **Start-up.** With `en`=1 at reset release, the first posedge is a boundary: `count`=0, `tick`=1, and `clk_out` rises at that posedge (even N) or at the following negedge (odd N).
- **Divisor change.** Latency from `div_load` to the new ratio is the remainder of the current period; at most N cycles.
  - The new ratio governs the period that starts at the boundary.
  - `load_ack` and `tick` are asserted in the same cycle.
- **Pulse widths.** `tick` and `load_ack` are each exactly one `clk_in` cycle wide.
- **Wrap.** `count` never exceeds N−1. A divisor of 2^W−1 uses the full counter range without overflow.

## Test plan
- **Reset.** Assert `rst` mid-high-phase → `clk_out` drops at once; with DIV_RST=3, `count`=2, `div_active`=3, `tick`=0, `load_ack`=0; after release with `en`=1, `tick`=1 on the first posedge.
- **Even N.** Load 4, `en`=1 → `clk_out` period 4 cycles, high exactly 2 (posedge to posedge), `tick` every 4 cycles, `count` cycles 0,1,2,3.
- **Odd N.** Load 5 → period 5 cycles, high 2.5 cycles (rise at a negedge, fall at a posedge), duty measured 50 %; the same check for N=3 and N=255 (W=8).
- **Mid-period change.** Running N=6, load 3 at `count`=2 → the 6-cycle period completes; `load_ack` coincides with `tick`; subsequent periods are 3; a second load of 7 at `count`=4 overwrites the pending value, so 7 is the divisor applied.
- **Clamping.** Load 0 and load 1 → `div_active`=2, `clk_out` toggles every cycle, `load_ack` pulses.
- **Enable.** Drop `en` at `count`=1 of N=8 → the period finishes, `clk_out` stays low, `count` holds at 7. Load 4 while idle → `div_active`=4 and `count`=3 on the next posedge. Raise `en` → a full 4-cycle period begins with `tick`.
